// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: requester count,
// opcode encodings and FSM state encoding.
package alu_pkg;

  localparam int unsigned NumReq = 2;

  // The arbiter never decodes these; they document what the shared ALU implements.
  typedef enum logic [2:0] {
    OpAnd = 3'd0,
    OpOr  = 3'd1,
    OpXor = 3'd2,
    OpNor = 3'd3,
    OpAdd = 3'd4,
    OpSub = 3'd5,
    OpSlt = 3'd6,
    OpSll = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins,
// a lone requester always wins.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic [NumReq-1:0] valid,
  input  logic              last,
  output logic [NumReq-1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// one-cycle execute with registered result, then hold the response until consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req_valid,
  output logic [NumReq-1:0] req_ready,
  input  logic [OPW-1:0]    req0_op,
  input  logic [OPW-1:0]    req1_op,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [WIDTH-1:0]  req1_b,
  output logic [NumReq-1:0] rsp_valid,
  input  logic [NumReq-1:0] rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [OPW-1:0]    alu_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              busy
);

  state_e             state_q, state_d;
  logic               last_q;
  logic               id_q;
  logic [OPW-1:0]     op_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [NumReq-1:0]  grant;
  logic               accept;

  rr_arbiter2 u_rr (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so nothing is offered while held in reset.
        req_ready = rst_n ? grant : '0;
        accept    = |(req_valid & req_ready);
        if (accept) state_d = StExec;
      end
      StExec: state_d = StResp;
      StResp: begin
        rsp_valid = id_q ? 2'b10 : 2'b01;
        if (rsp_ready[id_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      // Treat requester 1 as last granted so requester 0 wins the first tie.
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= grant[1];
        id_q   <= grant[1];
        op_q   <= grant[1] ? req1_op : req0_op;
        a_q    <= grant[1] ? req1_a : req0_a;
        b_q    <= grant[1] ? req1_b : req0_b;
      end
      if (state_q == StExec) res_q <= alu_result;
    end
  end

  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_result = res_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter: a transaction-level model predicts
// grants and results, a separate monitor checks each response as it appears.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [OPW-1:0]   req0_op = '0, req1_op = '0;
  logic [WIDTH-1:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = 2'b00;
  logic [WIDTH-1:0] rsp_result;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             busy;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req1_a     (req1_a),
    .req0_b     (req0_b),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpXor:   return a ^ b;
      OpNor:   return ~(a | b);
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a << b[4:0];
    endcase
  endfunction

  // The shared ALU the arbiter drives.
  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [2:0]  op;
    logic [31:0] a;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   grants[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  logic        pend[2];
  logic [2:0]  r_op[2];
  logic [31:0] r_a[2], r_b[2];
  logic        last_id = 1'b1;
  bit          occupied = 0;
  bit          auto_refill = 0;
  bit          allow_cancel = 0;
  int          refill_pct = 0;

  bit   holding = 0, just_done = 0, rand_stall = 0, force_wrong = 0;
  int   stall = 0, stall_next = 0;
  exp_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // One bench cycle: present requests, predict the grant, record any accept.
  task automatic step();
    logic [1:0] exp_g;
    logic       id;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!pend[k]) begin
        r_op[k] = 3'($urandom);
        r_a[k]  = $urandom;
        r_b[k]  = $urandom;
        if (auto_refill && $urandom_range(99) < refill_pct) pend[k] = 1'b1;
      end else if (allow_cancel && $urandom_range(15) == 0) begin
        pend[k] = 1'b0;
      end
    end
    req_valid = {pend[1], pend[0]};
    req0_op = r_op[0]; req0_a = r_a[0]; req0_b = r_b[0];
    req1_op = r_op[1]; req1_a = r_a[1]; req1_b = r_b[1];
    #1;
    exp_g = 2'b00;
    if (!occupied) begin
      if (pend[0] && pend[1]) exp_g = last_id ? 2'b01 : 2'b10;
      else exp_g = {pend[1], pend[0]};
    end
    check("req_ready", 64'(req_ready), 64'(exp_g));
    if (exp_g != 2'b00) begin
      id = exp_g[1];
      sbq.push_back('{id: id, res: ref_alu(r_op[id], r_a[id], r_b[id]), op: r_op[id],
                      a: r_a[id], cyc: cyc});
      last_id  = id;
      occupied = 1;
      pend[id] = 1'b0;
      grants.push_back(int'(id));
    end
  endtask

  // Response monitor and consumer; owns rsp_ready.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      holding   = 0;
      just_done = 0;
      rsp_ready = 2'b00;
    end else if (just_done) begin
      just_done = 0;
      check("idle_after_rsp", 64'({busy, rsp_valid}), 64'd0);
      rsp_ready = 2'($urandom);
    end else if (rsp_valid != 2'b00) begin
      if (!holding) begin
        if (sbq.size() == 0) begin
          check("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          cur = sbq.pop_front();
          holding = 1;
          check("rsp_valid", 64'(rsp_valid), cur.id ? 64'd2 : 64'd1);
          check("rsp_result", 64'(rsp_result), 64'(cur.res));
          check("rsp_latency", 64'(cyc - cur.cyc), 64'd2);
          check("alu_op_latched", 64'(alu_op), 64'(cur.op));
          check("alu_a_latched", 64'(alu_a), 64'(cur.a));
          stall = rand_stall ? int'($urandom_range(3)) : stall_next;
          stall_next = 0;
        end
      end else begin
        check("rsp_valid_stable", 64'(rsp_valid), cur.id ? 64'd2 : 64'd1);
        check("rsp_result_stable", 64'(rsp_result), 64'(cur.res));
        check("busy_ready_in_resp", 64'({busy, req_ready}), 64'b100);
      end
      if (holding) begin
        if (stall > 0) begin
          stall--;
          if (force_wrong || $urandom_range(1) == 1) rsp_ready = cur.id ? 2'b01 : 2'b10;
          else rsp_ready = 2'b00;
        end else begin
          rsp_ready = cur.id ? 2'b10 : 2'b01;
          holding   = 0;
          just_done = 1;
          occupied  = 0;
        end
      end
    end else begin
      rsp_ready = 2'($urandom);
    end
  end

  task automatic drain();
    int n = 0;
    auto_refill = 0;
    allow_cancel = 0;
    while ((pend[0] || pend[1] || occupied || just_done) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    pend[0] = 1'b0; pend[1] = 1'b0;
    // Reset with requests pending: nothing may be offered.
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu", 64'({alu_op, alu_a, alu_b} != '0), 64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention: both always valid; grants must alternate starting with 0.
    grants.delete();
    rand_stall = 1; auto_refill = 1; refill_pct = 100;
    n = 0;
    while (grants.size() < 4 && n < 60) begin step(); n++; end
    check("contention_count", 64'(grants.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("contention_order", 64'(grants[i]), 64'(i % 2));
    drain();

    // Single XOR from requester 0 with fixed latency and value.
    rand_stall = 0; stall_next = 0;
    r_op[0] = OpXor; r_a[0] = 32'hF0F0F0F0; r_b[0] = 32'h0FF00FF0; pend[0] = 1'b1;
    step();
    check("xor_accepted", 64'(occupied), 64'd1);
    step();
    step();
    check("xor_rsp_valid", 64'(rsp_valid), 64'd1);
    check("xor_rsp_result", 64'(rsp_result), 64'hFF00FF00);
    drain();

    // Backpressure on requester 0 while requester 1 waits.
    stall_next = 5;
    pend[0] = 1'b1; step();
    pend[1] = 1'b1;
    repeat (12) step();
    drain();

    // Wrong-bit ready for requester 1 must be ignored.
    force_wrong = 1; stall_next = 1;
    pend[1] = 1'b1;
    repeat (6) step();
    force_wrong = 0;
    drain();

    // Random traffic with cancellations and random backpressure.
    rand_stall = 1; auto_refill = 1; allow_cancel = 1; refill_pct = 40;
    repeat (600) step();
    drain();

    // Reset while a response is being held.
    rand_stall = 0; stall_next = 50;
    pend[1] = 1'b1;
    n = 0;
    while (!holding && n < 10) begin step(); n++; end
    check("reach_resp", 64'(holding), 64'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rsp_result", 64'(rsp_result), 64'd0);
    check("mid_rst_alu", 64'({alu_op, alu_a, alu_b} != '0), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    sbq.delete();
    occupied = 0; last_id = 1'b1; stall = 0; stall_next = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    grants.delete();
    pend[0] = 1'b1; pend[1] = 1'b1;
    step();
    check("post_rst_grant", 64'(grants.size() > 0 ? grants[0] : 9), 64'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
